// File: rtl/pipe_pkg.sv
// pipe_pkg: occupancy encoding and control-bit indices shared by pipeline stages,
// the decoder and the hazard unit.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    localparam int CTRL_MR         = 0;
    localparam int CTRL_MW         = 1;
    localparam int CTRL_REGWE      = 2;
    localparam int CTRL_BEQ        = 3;
    localparam int CTRL_BNE        = 4;
    localparam int CTRL_JAL        = 5;
    localparam int CTRL_JALR       = 6;
    localparam int CTRL_ALU_OP_LSB = 7;
    localparam int CTRL_ALU_OP_W   = 4;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: 2-entry head/skid storage with occupancy FSM; in_ready comes from a register
// so downstream back-pressure never chains combinationally into the upstream stage.
import pipe_pkg::*;

module pipe_skid_buf #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CTRL_W    = 16,
    parameter bit          ZERO_DATA = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    occ_t              occ_q, occ_d;
    logic              rdy_q, in_fire, out_fire, load_head, promote, drain, load_skid;
    logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
    logic [DATA_W-1:0] head_data, skid_data;

    assign in_ready  = rdy_q & !stall;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = (occ_q != OCC_EMPTY) & out_ready & !stall;
    assign load_head = in_fire & ((occ_q == OCC_EMPTY) | out_fire);
    assign promote   = out_fire & (occ_q == OCC_FULL);
    assign drain     = out_fire & !in_fire & (occ_q == OCC_ONE);
    assign load_skid = in_fire & !out_fire & (occ_q == OCC_ONE);

    always_comb begin
        occ_d = load_skid ? OCC_FULL : drain ? OCC_EMPTY : (promote | load_head) ? OCC_ONE : occ_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q     <= OCC_EMPTY;
            rdy_q     <= 1'b0;
            head_ctrl <= '0;
            skid_ctrl <= '0;
            head_data <= '0;
            skid_data <= '0;
        end else if (flush) begin
            occ_q     <= OCC_EMPTY;
            rdy_q     <= 1'b1;
            head_ctrl <= '0;
            skid_ctrl <= '0;
            if (ZERO_DATA) begin
                head_data <= '0;
                skid_data <= '0;
            end
        end else begin
            occ_q <= occ_d;
            rdy_q <= occ_d != OCC_FULL;
            if (load_head) begin
                head_ctrl <= in_ctrl;
                head_data <= in_data;
            end else if (promote) begin
                head_ctrl <= skid_ctrl;
                head_data <= skid_data;
            end else if (drain) begin
                head_ctrl <= '0;
            end
            if (load_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end else if (promote) begin
                skid_ctrl <= '0;
            end
        end
    end

    assign out_valid = occ_q != OCC_EMPTY;
    assign out_ctrl  = head_ctrl;
    assign out_data  = head_data;
    assign occupancy = occ_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with valid/ready handshake,
// stall, flush and an optional 2-entry skid buffer.
import pipe_pkg::*;

module pipe_stage_reg #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CTRL_W    = 16,
    parameter bit          SKID      = 0,
    parameter bit          ZERO_DATA = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    if (SKID) begin : g_skid
        pipe_skid_buf #(
            .DATA_W    (DATA_W),
            .CTRL_W    (CTRL_W),
            .ZERO_DATA (ZERO_DATA)
        ) u_skid (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .stall     (stall),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_ctrl   (in_ctrl),
            .in_data   (in_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_ctrl  (out_ctrl),
            .out_data  (out_data),
            .occupancy (occupancy)
        );
    end else begin : g_reg
        logic              alive_q, valid_q, in_fire, out_fire;
        logic [CTRL_W-1:0] ctrl_q;
        logic [DATA_W-1:0] data_q;

        // alive_q keeps in_ready low through reset and until the first edge after release
        assign in_ready = alive_q & !stall & (!valid_q | out_ready);
        assign in_fire  = in_valid & in_ready;
        assign out_fire = valid_q & out_ready & !stall;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                alive_q <= 1'b0;
                valid_q <= 1'b0;
                ctrl_q  <= '0;
                data_q  <= '0;
            end else if (flush) begin
                alive_q <= 1'b1;
                valid_q <= 1'b0;
                ctrl_q  <= '0;
                if (ZERO_DATA) data_q <= '0;
            end else begin
                alive_q <= 1'b1;
                if (in_fire) begin
                    valid_q <= 1'b1;
                    ctrl_q  <= in_ctrl;
                    data_q  <= in_data;
                end else if (out_fire) begin
                    valid_q <= 1'b0;
                    ctrl_q  <= '0;
                end
            end
        end

        assign out_valid = valid_q;
        assign out_ctrl  = ctrl_q;
        assign out_data  = data_q;
        assign occupancy = valid_q ? OCC_ONE : OCC_EMPTY;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of the pipeline register, run once against a SKID=0
// (ZERO_DATA=1) instance and once against a SKID=1 (ZERO_DATA=0) instance.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n, fl, st, iv, ordy;
    logic [15:0] ic;
    logic [31:0] id;
    logic        rdy0, rdy1, v0, v1;
    logic [15:0] c0, c1;
    logic [31:0] d0, d1;
    logic [1:0]  q0, q1;
    logic        mode;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(0), .ZERO_DATA(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(fl), .stall(st), .in_valid(iv), .in_ready(rdy0),
        .in_ctrl(ic), .in_data(id), .out_valid(v0), .out_ready(ordy), .out_ctrl(c0),
        .out_data(d0), .occupancy(q0)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(1), .ZERO_DATA(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(fl), .stall(st), .in_valid(iv), .in_ready(rdy1),
        .in_ctrl(ic), .in_data(id), .out_valid(v1), .out_ready(ordy), .out_ctrl(c1),
        .out_data(d1), .occupancy(q1)
    );

    wire        o_rdy   = mode ? rdy1 : rdy0;
    wire        o_valid = mode ? v1 : v0;
    wire [15:0] o_ctrl  = mode ? c1 : c0;
    wire [31:0] o_data  = mode ? d1 : d0;
    wire [1:0]  o_occ   = mode ? q1 : q0;

    function automatic logic [15:0] ctrl_of(input logic [31:0] x);
        return 16'hC000 | x[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s skid=%0d: got %h expected %h", tag, mode, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] x);
        iv = v;
        id = x;
        ic = ctrl_of(x);
    endtask

    initial begin
        logic [31:0] items [3];
        logic [31:0] rx [$];
        int          ptr;
        items = '{32'hA, 32'hB, 32'hC};
        rst_n = 1'b0; fl = 1'b0; st = 1'b0; ordy = 1'b0; mode = 1'b0;
        drive(1'b0, 32'h0);
        for (int m = 0; m < 2; m++) begin
            mode = m[0];
            rst_n = 1'b0; fl = 1'b0; st = 1'b0; ordy = 1'b0;
            drive(1'b0, 32'h0);
            #2;
            chk("rst_valid", {31'b0, o_valid}, 32'd0);
            chk("rst_ctrl", {16'b0, o_ctrl}, 32'd0);
            chk("rst_data", o_data, 32'd0);
            chk("rst_occ", {30'b0, o_occ}, 32'd0);
            chk("rst_ready", {31'b0, o_rdy}, 32'd0);
            tick();
            rst_n = 1'b1;
            tick();
            chk("rel_ready", {31'b0, o_rdy}, 32'd1);

            // streaming 1..8 then a bubble
            ordy = 1'b1;
            for (int i = 1; i <= 8; i++) begin
                drive(1'b1, i);
                #1;
                chk("stream_in_ready", {31'b0, o_rdy}, 32'd1);
                tick();
                chk("stream_valid", {31'b0, o_valid}, 32'd1);
                chk("stream_data", o_data, i);
                chk("stream_ctrl", {16'b0, o_ctrl}, {16'b0, ctrl_of(i)});
            end
            drive(1'b0, 32'h0);
            tick();
            chk("bubble_valid", {31'b0, o_valid}, 32'd0);
            chk("bubble_ctrl", {16'b0, o_ctrl}, 32'd0);
            chk("bubble_occ", {30'b0, o_occ}, 32'd0);

            // back-pressure: out_ready low for 3 cycles while offering A,B,C
            ptr = 0;
            rx.delete();
            for (int cyc = 0; cyc < 12; cyc++) begin
                ordy = cyc >= 3;
                drive(ptr < 3, ptr < 3 ? items[ptr] : 32'h0);
                #1;
                if (cyc == 2) begin
                    chk("bp_in_ready", {31'b0, o_rdy}, 32'd0);
                    chk("bp_occ", {30'b0, o_occ}, m ? 32'd2 : 32'd1);
                    chk("bp_head", o_data, 32'hA);
                end
                if (o_valid && ordy) rx.push_back(o_data);
                if (iv && o_rdy) ptr++;
                tick();
            end
            drive(1'b0, 32'h0);
            chk("bp_count", rx.size(), 32'd3);
            for (int k = 0; k < 3; k++)
                chk("bp_order", k < rx.size() ? rx[k] : 32'hDEAD, items[k]);

            // flush with a same-cycle input
            ordy = 1'b0;
            drive(1'b1, 32'h11);
            tick();
            drive(1'b1, 32'h22);
            tick();
            chk("fl_pre_occ", {30'b0, o_occ}, m ? 32'd2 : 32'd1);
            fl = 1'b1;
            drive(1'b1, 32'hDD);
            tick();
            fl = 1'b0;
            drive(1'b0, 32'h0);
            chk("fl_valid", {31'b0, o_valid}, 32'd0);
            chk("fl_ctrl", {16'b0, o_ctrl}, 32'd0);
            chk("fl_occ", {30'b0, o_occ}, 32'd0);
            chk("fl_data", o_data, m ? 32'h11 : 32'h0);
            #1;
            chk("fl_in_ready", {31'b0, o_rdy}, 32'd1);

            // stall holds head 0x5A, then flush beats stall
            drive(1'b1, 32'h5A);
            tick();
            st = 1'b1;
            ordy = 1'b1;
            drive(1'b1, 32'h77);
            #1;
            chk("st_in_ready", {31'b0, o_rdy}, 32'd0);
            for (int k = 0; k < 2; k++) begin
                tick();
                chk("st_valid", {31'b0, o_valid}, 32'd1);
                chk("st_head", o_data, 32'h5A);
                chk("st_occ", {30'b0, o_occ}, 32'd1);
            end
            fl = 1'b1;
            drive(1'b0, 32'h0);
            tick();
            fl = 1'b0;
            st = 1'b0;
            chk("flst_valid", {31'b0, o_valid}, 32'd0);
            chk("flst_occ", {30'b0, o_occ}, 32'd0);

            // asynchronous reset with entries held
            ordy = 1'b0;
            drive(1'b1, 32'h1);
            tick();
            drive(1'b1, 32'h2);
            tick();
            chk("mrst_pre_occ", {30'b0, o_occ}, m ? 32'd2 : 32'd1);
            rst_n = 1'b0;
            #1;
            chk("mrst_valid", {31'b0, o_valid}, 32'd0);
            chk("mrst_ctrl", {16'b0, o_ctrl}, 32'd0);
            chk("mrst_occ", {30'b0, o_occ}, 32'd0);
            chk("mrst_ready", {31'b0, o_rdy}, 32'd0);
            fl = 1'b1;
            st = 1'b1;
            tick();
            chk("mrst_hold_valid", {31'b0, o_valid}, 32'd0);
            rst_n = 1'b1;
            fl = 1'b0;
            st = 1'b0;
            drive(1'b0, 32'h0);
            tick();
            chk("mrst_rel_ready", {31'b0, o_rdy}, 32'd1);
            chk("mrst_rel_occ", {30'b0, o_occ}, 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
